// File: rtl/xbar_scheduler.sv
// Round-robin scheduler for a 4x4 crossbar: arbitrates head-flit requests per output and
// sequences the configuration units (load, commit, drive), holding connections until tail.
module xbar_scheduler #(
  parameter int unsigned CONF_HOLD = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [7:0] req_dest,
  input  logic [3:0] tail_done,
  output logic [3:0] grant,
  output logic [7:0] in_add,
  output logic [3:0] out_sel,
  output logic       load_en,
  output logic       conf_en,
  output logic [3:0] tristate,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StArb, StLoad, StConf} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][1:0] ptr_q, ptr_d;
  logic [7:0]      in_add_q, in_add_d;
  logic [3:0]      out_sel_q, out_sel_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      tristate_q, tristate_d;

  logic [3:0][3:0] cand;      // cand[j][i]: input i is eligible for output j
  logic [3:0]      win_vld;
  logic [3:0][1:0] win_idx;
  logic [1:0]      scan_idx;
  logic            conf_last;

  assign conf_last = (cnt_q == 2'(CONF_HOLD - 1));

  always_comb begin
    cand = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        cand[j][i] = req[i] & (req_dest[2*i +: 2] == 2'(j)) & ~grant_q[i] & ~tristate_q[j];
      end
    end
  end

  // Scan from the far end back to ptr so the nearest candidate is the last one written.
  always_comb begin
    win_vld  = '0;
    win_idx  = ptr_q;
    scan_idx = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = ptr_q[j] + 2'(k);
        if (cand[j][scan_idx]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = scan_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|win_vld) state_d = StArb;
      StArb:   state_d = (|win_vld) ? StLoad : StIdle;
      StLoad:  state_d = StConf;
      StConf:  if (conf_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_en = (state_q == StLoad);
    conf_en = (state_q == StConf);
    busy    = (state_q != StIdle);
  end

  always_comb begin
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    in_add_d   = in_add_q;
    out_sel_d  = out_sel_q;
    grant_d    = grant_q;
    tristate_d = tristate_q;

    // Releases apply in every state; a round never selects an output that is still active.
    for (int j = 0; j < 4; j++) begin
      if (tail_done[j] && tristate_q[j]) begin
        tristate_d[j]                = 1'b0;
        grant_d[in_add_q[2*j +: 2]] = 1'b0;
      end
    end

    if (state_q == StArb) begin
      out_sel_d = win_vld;
      for (int j = 0; j < 4; j++) begin
        if (win_vld[j]) in_add_d[2*j +: 2] = win_idx[j];
      end
    end

    if (state_q == StConf) begin
      if (conf_last) begin
        cnt_d     = '0;
        out_sel_d = '0;
        for (int j = 0; j < 4; j++) begin
          if (out_sel_q[j]) begin
            tristate_d[j]                = 1'b1;
            grant_d[in_add_q[2*j +: 2]] = 1'b1;
            ptr_d[j]                     = in_add_q[2*j +: 2] + 2'd1;
          end
        end
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      in_add_q   <= '0;
      out_sel_q  <= '0;
      grant_q    <= '0;
      tristate_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      in_add_q   <= in_add_d;
      out_sel_q  <= out_sel_d;
      grant_q    <= grant_d;
      tristate_q <= tristate_d;
    end
  end

  assign grant    = grant_q;
  assign in_add   = in_add_q;
  assign out_sel  = out_sel_q;
  assign tristate = tristate_q;

endmodule

// File: tb/tb_xbar_scheduler.sv
// Scoreboard bench for xbar_scheduler: a transaction-level round model predicts each round's
// selection and the resulting connections; a monitor checks every load_en round.
module tb_xbar_scheduler;

  localparam int unsigned Hold  = 1;
  localparam int unsigned Hold3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] req, tail_done, grant, out_sel, tristate;
  logic [7:0] req_dest, in_add;
  logic       load_en, conf_en, busy;

  logic       reset3_n;
  logic [3:0] req3, tail_done3, grant3, out_sel3, tristate3;
  logic [7:0] req_dest3, in_add3;
  logic       load_en3, conf_en3, busy3;

  xbar_scheduler #(.CONF_HOLD(Hold)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_dest(req_dest), .tail_done(tail_done),
    .grant(grant), .in_add(in_add), .out_sel(out_sel), .load_en(load_en), .conf_en(conf_en),
    .tristate(tristate), .busy(busy)
  );

  xbar_scheduler #(.CONF_HOLD(Hold3)) dut3 (
    .clk(clk), .reset_n(reset3_n), .req(req3), .req_dest(req_dest3), .tail_done(tail_done3),
    .grant(grant3), .in_add(in_add3), .out_sel(out_sel3), .load_en(load_en3),
    .conf_en(conf_en3), .tristate(tristate3), .busy(busy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns each output, who is granted, pending requests.
  int ptr_m [4];
  int owner_m [4];
  bit granted_m [4];
  bit pend_m [4];
  int dest_m [4];
  int in_add_m [4];

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] add;
  } round_t;
  round_t exp_q [$];
  int rounds_expected = 0;
  int busy_falls = 0;

  task automatic model_round();
    logic [3:0] sel;
    logic [7:0] add;
    int i;
    sel = '0;
    add = '0;
    for (int j = 0; j < 4; j++) begin
      if (owner_m[j] < 0) begin
        for (int k = 0; k < 4; k++) begin
          i = (ptr_m[j] + k) % 4;
          if (!sel[j] && pend_m[i] && !granted_m[i] && dest_m[i] == j) begin
            sel[j] = 1'b1;
            in_add_m[j] = i;
          end
        end
      end
    end
    if (sel != 4'b0) begin
      for (int j = 0; j < 4; j++) begin
        if (sel[j]) begin
          owner_m[j] = in_add_m[j];
          granted_m[in_add_m[j]] = 1'b1;
          ptr_m[j] = (in_add_m[j] + 1) % 4;
        end
        add[2*j +: 2] = 2'(in_add_m[j]);
      end
      exp_q.push_back('{sel: sel, add: add});
      rounds_expected++;
    end
  endtask

  function automatic logic [3:0] grant_mask();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = granted_m[i];
    return r;
  endfunction

  function automatic logic [3:0] tri_mask();
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = (owner_m[j] >= 0);
    return r;
  endfunction

  task automatic issue(input int i, input int d);
    req[i] = 1'b1;
    req_dest[2*i +: 2] = 2'(d);
    pend_m[i] = 1'b1;
    dest_m[i] = d;
  endtask

  task automatic release_model(input int j);
    if (owner_m[j] >= 0) begin
      granted_m[owner_m[j]] = 1'b0;
      owner_m[j] = -1;
    end
  endtask

  task automatic pulse(input int j);
    tail_done[j] = 1'b1;
    @(posedge clk); #1;
    tail_done[j] = 1'b0;
    release_model(j);
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (6) @(posedge clk);
    #1;
    while ((busy_falls != rounds_expected || busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("round_count", busy_falls, rounds_expected);
    check("grant", grant, grant_mask());
    check("tristate", tristate, tri_mask());
    for (int i = 0; i < 4; i++) begin
      if (granted_m[i] && pend_m[i]) begin
        req[i] = 1'b0;
        pend_m[i] = 1'b0;
      end
    end
  endtask

  task automatic release_all();
    for (int j = 0; j < 4; j++) begin
      if (owner_m[j] >= 0) begin
        pulse(j);
        model_round();
        settle();
      end
    end
  endtask

  // Requests are already driven this cycle; tail_done[j] lands d cycles into the round.
  task automatic round_with_release(input int d, input int j);
    model_round();
    repeat (d) @(posedge clk);
    #1;
    tail_done[j] = 1'b1;
    @(posedge clk); #1;
    tail_done[j] = 1'b0;
    release_model(j);
    model_round();
    settle();
  endtask

  initial begin : monitor
    round_t e;
    forever begin
      @(negedge clk);
      if (load_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL round_unexpected: out_sel=%b with no round expected", out_sel);
          e = '{sel: out_sel, add: in_add};
        end else begin
          e = exp_q.pop_front();
          check("round_out_sel", out_sel, e.sel);
          check("round_in_add", in_add, e.add);
        end
        for (int k = 0; k < Hold; k++) begin
          @(negedge clk);
          check("conf_en_high", conf_en, 1);
          check("out_sel_stable", out_sel, e.sel);
        end
        @(negedge clk);
        check("conf_en_low", conf_en, 0);
      end
    end
  end

  initial begin : busy_watch
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !busy) busy_falls++;
      prev = busy;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 4; i++) begin
      ptr_m[i] = 0; owner_m[i] = -1; granted_m[i] = 0; pend_m[i] = 0; dest_m[i] = 0;
      in_add_m[i] = 0;
    end
    reset_n = 1'b0; reset3_n = 1'b0;
    req = '0; req_dest = '0; tail_done = '0;
    req3 = '0; req_dest3 = '0; tail_done3 = '0;
    #1;
    check("rst_outputs", {grant, tristate, out_sel, in_add, load_en, conf_en, busy}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; reset3_n = 1'b1;

    // Single request, cycle-exact.
    @(posedge clk); #1;
    issue(2, 1);
    model_round();
    @(posedge clk); #1;
    check("single_c1_busy", busy, 1);
    check("single_c1_load", load_en, 0);
    @(posedge clk); #1;
    check("single_c2_load", load_en, 1);
    check("single_c2_in_add", in_add[3:2], 2);
    check("single_c2_out_sel", out_sel, 4'b0010);
    @(posedge clk); #1;
    check("single_c3_conf", conf_en, 1);
    @(posedge clk); #1;
    check("single_c4_grant", grant, 4'b0100);
    check("single_c4_tristate", tristate, 4'b0010);
    settle();
    release_all();

    // Contention on output 0 and pointer wrap.
    issue(0, 0); issue(1, 0); issue(3, 0);
    model_round(); settle();
    check("cont_first", grant, 4'b0001);
    pulse(0); model_round(); settle();
    check("cont_second", grant, 4'b0010);
    pulse(0); model_round(); settle();
    check("cont_third", grant, 4'b1000);
    pulse(0); model_round(); settle();
    issue(3, 0); issue(0, 0);
    model_round(); settle();
    check("cont_wrap", grant, 4'b0001);
    release_all();
    release_all();

    // Parallel round.
    issue(0, 3); issue(1, 2);
    model_round(); settle();
    check("par_grant", grant, 4'b0011);
    check("par_tristate", tristate, 4'b1100);
    release_all();

    // Edge events.
    pulse(2); model_round(); settle();
    issue(0, 3); model_round(); settle();
    issue(1, 3); model_round(); settle();
    issue(2, 1); round_with_release(1, 3);
    check("edge_arb_grant", grant, 4'b0110);
    check("edge_arb_tristate", tristate, 4'b1010);
    release_all();
    issue(0, 3); model_round(); settle();
    issue(1, 3); model_round(); settle();
    issue(2, 1); round_with_release(3, 3);
    check("edge_conf_grant", grant, 4'b0110);
    release_all();

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend_m[i] && !granted_m[i] && $urandom_range(0, 1) == 1)
            issue(i, int'($urandom_range(0, 3)));
        end
      end else begin
        pulse(int'($urandom_range(0, 3)));
      end
      model_round();
      settle();
    end
    release_all();
    release_all();
    check("scoreboard_empty", exp_q.size(), 0);

    // CONF_HOLD = 3 instance: reset during the second commit cycle.
    @(posedge clk); #1;
    req3[0] = 1'b1; req_dest3[1:0] = 2'd0;
    n = 0;
    while (!grant3[0] && n < 30) begin @(posedge clk); #1; n++; end
    check("d3_first_grant", grant3, 4'b0001);
    req3[0] = 1'b0;
    tail_done3[0] = 1'b1;
    @(posedge clk); #1;
    tail_done3[0] = 1'b0;
    check("d3_release", tristate3, 0);
    req3[1:0] = 2'b11; req_dest3[3:0] = 4'd0;
    n = 0;
    while (!conf_en3 && n < 30) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check("d3_conf_second", conf_en3, 1);
    check("d3_winner", in_add3[1:0], 1);
    #2;
    reset3_n = 1'b0;
    #1;
    check("d3_rst_outputs", {grant3, tristate3, out_sel3, in_add3, load_en3, conf_en3, busy3}, 0);
    @(posedge clk); #1;
    check("d3_rst_hold", {grant3, tristate3}, 0);
    reset3_n = 1'b1;
    n = 0;
    while (grant3 == 4'b0 && n < 30) begin @(posedge clk); #1; n++; end
    check("d3_after_rst_grant", grant3, 4'b0001);
    check("d3_after_rst_in_add", in_add3[1:0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_scheduler.md
# xbar_scheduler

Round-robin crossbar scheduler for the 4x4 router switch. It arbitrates head-flit requests from the four input ports for the four output ports and sequences the per-output crossbar configuration units. The sequence is load the selected input address, then commit it with `conf_en`, then drive the output. Each connection is held until the packet's tail passes, and the scheduler sits between the input buffers and the crossbar configuration units.

## Interface
- `CONF_HOLD`, default 1: cycles `conf_en` stays high per round; legal range 1..4.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  `req[i]`: input i holds a head flit; held until `grant[i]`.
- `req_dest`  in  8  `req_dest[2i+1:2i]`: destination output of input i; stable while `req[i]` is high.
- `tail_done`  in  4  `tail_done[j]`: tail flit left output j; one-cycle pulse.
- `grant`  out  4  `grant[i]`: input i owns a connection.
- `in_add`  out  8  `in_add[2j+1:2j]`: input index routed to output j.
- `out_sel`  out  4  outputs being configured in the current round.
- `load_en`  out  1  load strobe to the configuration units.
- `conf_en`  out  1  commit strobe to the configuration units.
- `tristate`  out  4  `tristate[j]`: output j driven (connection active).
- `busy`  out  1  FSM not in IDLE.

## Operation
- Reset values: all outputs 0; priority pointers `ptr[0..3]` = 0; FSM in IDLE; `conf_en` counter 0.
- Candidate definition: `cand[j][i] = req[i] & (req_dest_i == j) & ~grant[i] & ~tristate[j]`. All terms use registered `grant`/`tristate`.
- Winner of output j: the first i with `cand[j][i]`, searching cyclically from `ptr[j]`.
- FSM states:
  - **IDLE**: go to ARB when any `cand[j][i]` is 1; otherwise stay.
  - **ARB** (1 cycle): register winners into `in_add[j]` and set `out_sel[j]` for every output with a winner. If none (the request dropped), return to IDLE. Otherwise go to LOAD. `in_add` fields of unselected outputs are unchanged.
  - **LOAD** (1 cycle): `load_en` = 1, `out_sel` held; go to CONF.
  - **CONF** (`CONF_HOLD` cycles, counted):
    - `conf_en` = 1 for the whole state.
    - On exit, for each selected j: set `tristate[j]`, set `grant[in_add[j]]`, and update `ptr[j]` to (winner + 1) mod 4.
    - Clear `out_sel` and go to IDLE.
- Release: `tail_done[j]` with `tristate[j]` = 1 clears `tristate[j]` and `grant[in_add[j]]` at the next edge, in any state. `in_add[j]` keeps its old value. `tail_done[j]` with `tristate[j]` = 0 is ignored.
- Exclusivity: each input requests one destination, so one round never grants an input twice. Several outputs may be configured in one round with a single `load_en`/`conf_en` sequence.
- Pointer arithmetic: 2-bit wrap, so 3 + 1 = 0.

## Timing
- Cycle n is the cycle after rising edge n. A request meeting edge 1 in IDLE produces:
  - ARB in cycle 1.
  - `load_en`/`out_sel`/`in_add` valid in cycle 2.
  - `conf_en` in cycles 3..2+`CONF_HOLD`.
  - `grant`/`tristate` high from cycle 3+`CONF_HOLD`, with the FSM back in IDLE.
  - Latency with `CONF_HOLD` = 1: 4 cycles from request to grant.
- Release at the same edge as ARB: the released output is not a candidate in that ARB. It is arbitrated in the next round, earliest two cycles later.
- `tail_done` during LOAD/CONF for an already-active output is applied immediately. It does not disturb the round in progress.
- `in_add` and `out_sel` change only at the ARB→LOAD edge and the CONF→IDLE edge. They are stable throughout LOAD and CONF.
- Reset mid-round: all outputs drop to 0 asynchronously and the round is aborted. No pointer update is made.

## Test plan
- Reset: assert `reset_n` = 0 mid-stream -> every output 0 immediately; first round after release uses `ptr` = 0.
- Single request: input 2 to output 1, `CONF_HOLD` = 1 -> expected response:
  - `load_en` in cycle 2, with `in_add[3:2]` = 2 and `out_sel` = 0010.
  - `conf_en` in cycle 3.
  - Cycle 4: `grant` = 0100, `tristate` = 0010, `ptr[1]` = 3.
- Contention: inputs 0, 1 and 3 all to output 0 -> expected grant order:
  - Input 0 is granted first.
  - After `tail_done[0]`, input 1 is granted.
  - After the next `tail_done[0]`, input 3 is granted and `ptr[0]` wraps to 0.
- Parallel round: input 0 to output 3 and input 1 to output 2 together -> one `load_en` pulse with `out_sel` = 1100, then `grant` = 0011 and `tristate` = 1100.
- Edge events: `tail_done[2]` while output 2 is inactive -> no change. `tail_done[3]` on the same edge as an ARB for output 3 -> output 3 is not granted in that round and is granted in the next round.
- `CONF_HOLD` = 3 with reset asserted in the second `conf_en` cycle -> `conf_en` falls at once; `grant`, `tristate` and `ptr` remain 0.
